instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch front-end for the RV32E core. Drives the SPI memory reader
//  (start/address/data/done handshake) upstream of decode.
//  Sequences the PC, converts flash byte order to little-endian and buffers one
//  instruction behind a valid/ready handshake. Supports redirects (branch/jump/trap)
//  and flags misaligned targets.
// PARAMETERS
//  ADDR_WIDTH  24     byte address width of flash space; PC width
//  RESET_PC    24'h0  PC loaded on reset
//  GAP_CYCLES  1      min cycles mem_start_fetch is held low between requests (>=1)
// PORTS
//  clk             in   1           system clock
//  rst_n           in   1           reset, synchronous, active-low
//  mem_start_fetch out  1           request to memory reader; held high until done consumed
//  mem_address     out  ADDR_WIDTH  fetch byte address (== PC register)
//  mem_data        in   32          memory read data; first received byte in [31:24]
//  mem_done        in   1           memory read complete; mem_data valid while high
//  instr_valid     out  1           instr/instr_pc valid for decode
//  instr           out  32          instruction, little-endian assembled
//  instr_pc        out  ADDR_WIDTH  address of instr
//  instr_ready     in   1           decode accepts instr this cycle
//  redirect_valid  in   1           load redirect_pc, flush fetch
//  redirect_pc     in   ADDR_WIDTH  redirect target
//  fetch_fault     out  1           misaligned redirect target; sticky until aligned redirect
// BEHAVIOUR
//  Clock/reset: single clock clk; rst_n synchronous active-low, sampled on clk rising edge.
//  Reset: state=GAP, gap_cnt=0, pc=RESET_PC, mem_start_fetch=0, instr_valid=0,
//   instr=0, instr_pc=0, fetch_fault=0. Reset mid-fetch aborts; outputs return to
//   reset values at that edge.
//  All outputs registered. mem_address=pc, stable for the whole REQ state.
//  States:
//   GAP:   start=0; gap_cnt++; at gap_cnt==GAP_CYCLES-1 -> REQ (start=1 next cycle).
//   REQ:   start=1; wait mem_done.
//          On mem_done && (!instr_valid || instr_ready):
//           instr<={d[7:0],d[15:8],d[23:16],d[31:24]}; instr_pc<=pc; instr_valid<=1;
//           pc<=pc+4; start<=0; gap_cnt<=0 -> GAP.
//          On mem_done with buffer full and not accepted: stay in REQ, start held high
//           (memory reader holds data). Load on the first cycle instr_ready=1.
//   FAULT: start=0, instr_valid=0, fetch_fault=1; leave only on aligned redirect.
//  Handshake: transfer on clk edge with instr_valid&&instr_ready. instr/instr_pc are
//   stable while valid&&!ready. instr_valid clears on transfer unless a new instr
//   loads the same edge (back-to-back).
//  Prefetch: the next REQ overlaps with a held buffer; at most one instr buffered.
//  Redirect (highest priority, any state):
//   pc<=redirect_pc; instr_valid<=0; start<=0; gap_cnt<=0.
//   redirect_pc[1:0]==0 -> GAP, fetch_fault<=0; else -> FAULT, fetch_fault<=1.
//   Any mem_done in the redirect cycle is discarded.
//   A transfer coinciding with the redirect still counts as accepted.
//   Aborting REQ by dropping start is legal; the reader returns to idle.
//  PC arithmetic: modulo 2^ADDR_WIDTH; 0xFFFFFC+4 -> 0x000000. pc[1:0] always 0 outside FAULT.
//  Latency: after rst_n rises, start=1 from the first edge (GAP_CYCLES=1).
//   mem_done -> instr_valid: 1 clk. Min cycles between requests: GAP_CYCLES.
// TESTING
//  1 Reset, RESET_PC=0, flash[0..3]=13 05 10 00 -> mem_address=0x000000,
//    instr=0x00100513, instr_pc=0; start low exactly 1 cycle; next mem_address=0x000004.
//  2 instr_ready=0, 2nd fetch done -> start stays 1, instr unchanged.
//    Ready pulse -> 2nd instr (pc 0x4) loaded on the following edge.
//  3 redirect_pc=0x000100 mid-REQ -> start=0 and instr_valid=0 next edge;
//    the late mem_done is ignored; next request mem_address=0x000100.
//  4 redirect_pc=0x000102 -> fetch_fault=1, no start.
//    Then redirect 0x000200 -> fault=0, fetch at 0x000200.
//  5 redirect 0xFFFFFC, fetch completes -> instr_pc=0xFFFFFC, next mem_address=0x000000.
//  6 rst_n=0 for 1 cycle during REQ with instr_valid=1 -> all outputs reset next edge;
//    refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: sequences the PC, drives the SPI memory reader
// request/done handshake and buffers one byte-swapped instruction for decode.
module instr_fetch #(
    parameter int unsigned            ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_start_fetch,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_data,
    input  logic                  mem_done,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_fault
);

    localparam int unsigned       GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_REQ   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t                  state;
    logic [GAP_W-1:0]        gap_cnt;
    logic [ADDR_WIDTH-1:0]   pc;

    // The request address is the PC register itself, so it is stable through REQ.
    assign mem_address = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_GAP;
            gap_cnt         <= '0;
            pc              <= RESET_PC;
            mem_start_fetch <= 1'b0;
            instr_valid     <= 1'b0;
            instr           <= '0;
            instr_pc        <= '0;
            fetch_fault     <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect flushes everything; a coincident mem_done is dropped.
            pc              <= redirect_pc;
            instr_valid     <= 1'b0;
            mem_start_fetch <= 1'b0;
            gap_cnt         <= '0;
            if (redirect_pc[1:0] == 2'b00) begin
                state       <= S_GAP;
                fetch_fault <= 1'b0;
            end else begin
                state       <= S_FAULT;
                fetch_fault <= 1'b1;
            end
        end else begin
            // Decode consumed the buffer; a same-edge load below overrides this.
            if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end

            case (state)
                S_GAP: begin
                    mem_start_fetch <= 1'b0;
                    gap_cnt         <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == GAP_LAST) begin
                        state           <= S_REQ;
                        mem_start_fetch <= 1'b1;
                    end
                end

                S_REQ: begin
                    mem_start_fetch <= 1'b1;
                    // Reader holds data while start stays high, so wait for buffer space.
                    if (mem_done && (!instr_valid || instr_ready)) begin
                        instr           <= {mem_data[7:0], mem_data[15:8],
                                            mem_data[23:16], mem_data[31:24]};
                        instr_pc        <= pc;
                        instr_valid     <= 1'b1;
                        pc              <= pc + ADDR_WIDTH'(4);
                        mem_start_fetch <= 1'b0;
                        gap_cnt         <= '0;
                        state           <= S_GAP;
                    end
                end

                S_FAULT: begin
                    mem_start_fetch <= 1'b0;
                    instr_valid     <= 1'b0;
                    fetch_fault     <= 1'b1;
                end

                default: begin
                    state           <= S_GAP;
                    gap_cnt         <= '0;
                    mem_start_fetch <= 1'b0;
                end
            endcase
        end
    end

endmodule
